// File: rtl/decode_forward_pkg.sv
// Shared definitions for the decode/forward stage.
//   XLEN, RA_W, CTRL_W : datapath, register-address and control-bundle widths
//   REG_ZERO           : hard-wired zero register, never a forward target
//   de_reg_t           : contents of the D/E pipeline register
package decode_forward_pkg;
  localparam int XLEN   = 32;
  localparam int RA_W   = 5;
  localparam int CTRL_W = 8;

  localparam logic [RA_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   valA;
    logic [XLEN-1:0]   valB;
    logic [RA_W-1:0]   dstReg;
    logic              writeReg;
    logic              isLoad;
    logic [CTRL_W-1:0] ctrl;
  } de_reg_t;
endpackage

// File: rtl/decode_forward_if.sv
// Bus bundle between decode_forward and its neighbours.
//   d_*      : instruction sitting in the F/D register plus its regfile data
//   e_aluOut : result of the instruction currently in E
//   m_*, w_* : M and W stage writeback candidates
//   e_hold, flush : downstream stall and branch squash
//   d_stall  : combinational fetch/decode stall
//   e_*      : D/E register contents
// slave = decode_forward side, master = the surrounding pipeline.
interface decode_forward_if;
  import decode_forward_pkg::*;

  logic              d_valid;
  logic [RA_W-1:0]   d_srcA, d_srcB;
  logic              d_useA, d_useB;
  logic [RA_W-1:0]   d_dstReg;
  logic              d_writeReg;
  logic              d_isLoad;
  logic [CTRL_W-1:0] d_ctrl;
  logic [XLEN-1:0]   d_rvalA, d_rvalB;
  logic [XLEN-1:0]   e_aluOut;
  logic [RA_W-1:0]   m_dstReg;
  logic              m_writeReg;
  logic [XLEN-1:0]   m_val;
  logic [RA_W-1:0]   w_dstReg;
  logic              w_writeReg;
  logic [XLEN-1:0]   w_val;
  logic              e_hold;
  logic              flush;
  logic              d_stall;
  logic              e_valid;
  logic [XLEN-1:0]   e_valA, e_valB;
  logic [RA_W-1:0]   e_dstReg;
  logic              e_writeReg;
  logic              e_isLoad;
  logic [CTRL_W-1:0] e_ctrl;

  modport slave (
    input  d_valid, d_srcA, d_srcB, d_useA, d_useB, d_dstReg, d_writeReg,
           d_isLoad, d_ctrl, d_rvalA, d_rvalB, e_aluOut, m_dstReg, m_writeReg,
           m_val, w_dstReg, w_writeReg, w_val, e_hold, flush,
    output d_stall, e_valid, e_valA, e_valB, e_dstReg, e_writeReg, e_isLoad,
           e_ctrl
  );

  modport master (
    output d_valid, d_srcA, d_srcB, d_useA, d_useB, d_dstReg, d_writeReg,
           d_isLoad, d_ctrl, d_rvalA, d_rvalB, e_aluOut, m_dstReg, m_writeReg,
           m_val, w_dstReg, w_writeReg, w_val, e_hold, flush,
    input  d_stall, e_valid, e_valA, e_valB, e_dstReg, e_writeReg, e_isLoad,
           e_ctrl
  );
endinterface

// File: rtl/decode_forward_fwd_mux.sv
// Per-source operand select: E forward, then M, then W, then regfile.
// Also flags a load-use hazard for this source.
//   src, use_src, d_valid, rval : decode-side operand request
//   e_* / m_* / w_*             : producer stages (E state from the D/E reg)
//   val, hazard                 : selected operand, load-use flag
module decode_forward_fwd_mux
  import decode_forward_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  logic            use_src,
  input  logic            d_valid,
  input  logic [XLEN-1:0] rval,
  input  logic            e_valid,
  input  logic            e_writeReg,
  input  logic [RA_W-1:0] e_dstReg,
  input  logic            e_isLoad,
  input  logic [XLEN-1:0] e_aluOut,
  input  logic [RA_W-1:0] m_dstReg,
  input  logic            m_writeReg,
  input  logic [XLEN-1:0] m_val,
  input  logic [RA_W-1:0] w_dstReg,
  input  logic            w_writeReg,
  input  logic [XLEN-1:0] w_val,
  output logic [XLEN-1:0] val,
  output logic            hazard
);
  logic e_hit;

  // A valid writer in E matching this source; load data isn't ready yet.
  assign e_hit = e_valid & e_writeReg & (e_dstReg == src);

  always_comb begin
    val = rval;
    if (src == REG_ZERO)                     val = '0;
    else if (e_hit && !e_isLoad)             val = e_aluOut;
    else if (m_writeReg && m_dstReg == src)  val = m_val;
    // W write lands in the regfile at the edge, so its data isn't in rval yet.
    else if (w_writeReg && w_dstReg == src)  val = w_val;
  end

  assign hazard = d_valid & use_src & (src != REG_ZERO) & e_hit & e_isLoad;
endmodule

// File: rtl/decode_forward.sv
// Decode stage: operand forwarding, load-use stall and the D/E register.
//   clk, reset : clock, synchronous active-high reset
//   bus        : decode_forward_if.slave (D inputs, producer stages, E outputs)
//   stall_cnt  : load-use stall cycle counter, present only when
//                DECODE_STALL_CNT_EN is defined (saturates at 16'hFFFF)
module decode_forward
  import decode_forward_pkg::*;
(
  input  logic clk,
  input  logic reset,
  decode_forward_if.slave bus
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int NUM_SRC = 2;  // index 0 = A, 1 = B

  logic [NUM_SRC-1:0][RA_W-1:0] src;
  logic [NUM_SRC-1:0]           use_src;
  logic [NUM_SRC-1:0][XLEN-1:0] rval;
  logic [NUM_SRC-1:0][XLEN-1:0] fwd_val;
  logic [NUM_SRC-1:0]           src_hz;
  logic                         hazard;
  de_reg_t                      de_q, de_d;

  assign src     = {bus.d_srcB, bus.d_srcA};
  assign use_src = {bus.d_useB, bus.d_useA};
  assign rval    = {bus.d_rvalB, bus.d_rvalA};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    decode_forward_fwd_mux u_fwd (
      .src        (src[g]),
      .use_src    (use_src[g]),
      .d_valid    (bus.d_valid),
      .rval       (rval[g]),
      .e_valid    (de_q.valid),
      .e_writeReg (de_q.writeReg),
      .e_dstReg   (de_q.dstReg),
      .e_isLoad   (de_q.isLoad),
      .e_aluOut   (bus.e_aluOut),
      .m_dstReg   (bus.m_dstReg),
      .m_writeReg (bus.m_writeReg),
      .m_val      (bus.m_val),
      .w_dstReg   (bus.w_dstReg),
      .w_writeReg (bus.w_writeReg),
      .w_val      (bus.w_val),
      .val        (fwd_val[g]),
      .hazard     (src_hz[g])
    );
  end

  assign hazard = |src_hz;
  // A flushed instruction is discarded anyway, so its hazard must not stall.
  assign bus.d_stall = bus.e_hold | (hazard & ~bus.flush);

  always_comb begin
    de_d          = '0;
    de_d.valid    = bus.d_valid;
    de_d.valA     = fwd_val[0];
    de_d.valB     = fwd_val[1];
    de_d.dstReg   = bus.d_dstReg;
    de_d.writeReg = bus.d_writeReg & bus.d_valid;
    de_d.isLoad   = bus.d_isLoad & bus.d_valid;
    de_d.ctrl     = bus.d_ctrl;
  end

  always_ff @(posedge clk) begin
    if (reset)                       de_q <= '0;
    else if (bus.e_hold)             de_q <= de_q;
    else if (bus.flush || hazard)    de_q <= '0;  // bubble
    else                             de_q <= de_d;
  end

  assign bus.e_valid    = de_q.valid;
  assign bus.e_valA     = de_q.valA;
  assign bus.e_valB     = de_q.valB;
  assign bus.e_dstReg   = de_q.dstReg;
  assign bus.e_writeReg = de_q.writeReg;
  assign bus.e_isLoad   = de_q.isLoad;
  assign bus.e_ctrl     = de_q.ctrl;

`ifdef DECODE_STALL_CNT_EN
  // Counts only cycles where the bubble is really inserted.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (hazard && !bus.flush && !bus.e_hold && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_decode_forward.sv
// Self-checking bench for decode_forward: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_decode_forward;
  import decode_forward_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_forward_if bus();

`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] exp_cnt, cnt_next;
`endif

  decode_forward dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DECODE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  de_reg_t exp_e, exp_next;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Freshest value of a register: first matching producer in age order,
  // falling back to the regfile read. r0 is always zero.
  function automatic logic [XLEN-1:0] pick(input logic [RA_W-1:0] s, input logic [XLEN-1:0] rv);
    logic [RA_W-1:0] pd[3];
    bit              pw[3];
    logic [XLEN-1:0] pv[3];
    if (s == 0) return '0;
    pd[0] = exp_e.dstReg; pw[0] = exp_e.valid && exp_e.writeReg && !exp_e.isLoad; pv[0] = bus.e_aluOut;
    pd[1] = bus.m_dstReg; pw[1] = bus.m_writeReg; pv[1] = bus.m_val;
    pd[2] = bus.w_dstReg; pw[2] = bus.w_writeReg; pv[2] = bus.w_val;
    for (int i = 0; i < 3; i++)
      if (pw[i] && pd[i] == s) return pv[i];
    return rv;
  endfunction

  function automatic bit load_use(input logic [RA_W-1:0] s, input logic u);
    return bus.d_valid && u && s != 0 && exp_e.valid && exp_e.isLoad &&
           exp_e.writeReg && exp_e.dstReg == s;
  endfunction

  function automatic bit model_hz();
    return load_use(bus.d_srcA, bus.d_useA) || load_use(bus.d_srcB, bus.d_useB);
  endfunction

  // Predict the edge from the inputs currently driven, then advance.
  task automatic step();
    bit hz;
    hz = model_hz();
    if (reset)                        exp_next = '0;
    else if (bus.e_hold)              exp_next = exp_e;
    else if (bus.flush || hz)         exp_next = '0;
    else begin
      exp_next.valid    = bus.d_valid;
      exp_next.valA     = pick(bus.d_srcA, bus.d_rvalA);
      exp_next.valB     = pick(bus.d_srcB, bus.d_rvalB);
      exp_next.dstReg   = bus.d_dstReg;
      exp_next.writeReg = bus.d_writeReg && bus.d_valid;
      exp_next.isLoad   = bus.d_isLoad && bus.d_valid;
      exp_next.ctrl     = bus.d_ctrl;
    end
`ifdef DECODE_STALL_CNT_EN
    if (reset) cnt_next = 0;
    else if (hz && !bus.flush && !bus.e_hold && exp_cnt != 16'hFFFF) cnt_next = exp_cnt + 16'd1;
    else cnt_next = exp_cnt;
`endif
    @(posedge clk);
    #1;
    exp_e = exp_next;
`ifdef DECODE_STALL_CNT_EN
    exp_cnt = cnt_next;
`endif
  endtask

  task automatic idle();
    bus.d_valid = 0; bus.d_srcA = 0; bus.d_srcB = 0; bus.d_useA = 0; bus.d_useB = 0;
    bus.d_dstReg = 0; bus.d_writeReg = 0; bus.d_isLoad = 0; bus.d_ctrl = 0;
    bus.d_rvalA = 0; bus.d_rvalB = 0; bus.e_aluOut = 0;
    bus.m_dstReg = 0; bus.m_writeReg = 0; bus.m_val = 0;
    bus.w_dstReg = 0; bus.w_writeReg = 0; bus.w_val = 0;
    bus.e_hold = 0; bus.flush = 0;
  endtask

  // Cycle-by-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("e_bundle", 128'({bus.e_valid, bus.e_valA, bus.e_valB, bus.e_dstReg,
                            bus.e_writeReg, bus.e_isLoad, bus.e_ctrl}), 128'(exp_e));
      chk("d_stall", 128'(bus.d_stall), 128'(bus.e_hold | (model_hz() & ~bus.flush)));
`ifdef DECODE_STALL_CNT_EN
      chk("stall_cnt", 128'(stall_cnt), 128'(exp_cnt));
`endif
    end
  end

  initial begin
    idle();
    reset = 1;
    step(); step();
    chk_en = 1;
    chk("rst_valid", 128'(bus.e_valid), 0);
    chk("rst_valA", 128'(bus.e_valA), 0);
    reset = 0;

    // W-stage forward beats stale regfile data
    idle(); bus.d_valid = 1; bus.d_useA = 1; bus.d_srcA = 3; bus.d_rvalA = 'h11;
    bus.w_writeReg = 1; bus.w_dstReg = 3; bus.w_val = 'h55;
    bus.d_dstReg = 7; bus.d_writeReg = 1;
    step();
    chk("wfwd_dut", 128'(bus.e_valA), 'h55);
    chk("wfwd_model", 128'(exp_e.valA), 'h55);

    // E forward has priority over M
    idle(); bus.d_valid = 1; bus.d_dstReg = 5; bus.d_writeReg = 1;
    step();
    idle(); bus.d_valid = 1; bus.d_useB = 1; bus.d_srcB = 5; bus.d_rvalB = 'hC;
    bus.e_aluOut = 'hA; bus.m_dstReg = 5; bus.m_writeReg = 1; bus.m_val = 'hB;
    step();
    chk("e_over_m_dut", 128'(bus.e_valB), 'hA);
    chk("e_over_m_model", 128'(exp_e.valB), 'hA);

    // Load-use: one bubble, then M forwards the load data
    idle(); bus.d_valid = 1; bus.d_dstReg = 2; bus.d_writeReg = 1; bus.d_isLoad = 1;
    step();
    idle(); bus.d_valid = 1; bus.d_useA = 1; bus.d_srcA = 2; bus.d_rvalA = 'h1;
    bus.d_dstReg = 9; bus.d_writeReg = 1;
    #1 chk("lu_stall", 128'(bus.d_stall), 1);
    step();
    chk("lu_bubble", 128'(bus.e_valid), 0);
    bus.m_writeReg = 1; bus.m_dstReg = 2; bus.m_val = 'h77;
    #1 chk("lu_stall_clr", 128'(bus.d_stall), 0);
    step();
    chk("lu_fwd", 128'(bus.e_valA), 'h77);
    chk("lu_valid", 128'(bus.e_valid), 1);
`ifdef DECODE_STALL_CNT_EN
    chk("cnt_one", 128'(stall_cnt), 1);
`endif

    // r0: never forwarded, never a hazard
    idle(); bus.d_valid = 1; bus.d_dstReg = 0; bus.d_writeReg = 1; bus.d_isLoad = 1;
    step();
    idle(); bus.d_valid = 1; bus.d_useA = 1; bus.d_srcA = 0; bus.d_rvalA = 'h33;
    bus.m_dstReg = 0; bus.m_writeReg = 1; bus.m_val = 'hFF;
    #1 chk("r0_nostall", 128'(bus.d_stall), 0);
    step();
    chk("r0_val", 128'(bus.e_valA), 0);
    chk("r0_valid", 128'(bus.e_valid), 1);

    // Flush during load-use: no stall, bubble
    idle(); bus.d_valid = 1; bus.d_dstReg = 4; bus.d_writeReg = 1; bus.d_isLoad = 1;
    step();
    idle(); bus.d_valid = 1; bus.d_useB = 1; bus.d_srcB = 4; bus.flush = 1;
    #1 chk("flush_nostall", 128'(bus.d_stall), 0);
    step();
    chk("flush_bubble", 128'(bus.e_valid), 0);

    // e_hold freezes E for three cycles
    idle(); bus.d_valid = 1; bus.d_useA = 1; bus.d_srcA = 1; bus.d_rvalA = 'h1234;
    bus.d_ctrl = 'h5A; bus.d_dstReg = 6; bus.d_writeReg = 1;
    step();
    chk("hold_load", 128'(bus.e_valA), 'h1234);
    for (int i = 0; i < 3; i++) begin
      idle(); bus.e_hold = 1; bus.d_valid = 1; bus.d_useA = 1; bus.d_srcA = 1;
      bus.d_rvalA = $urandom; bus.d_ctrl = 8'($urandom); bus.d_dstReg = 9;
      #1 chk("hold_stall", 128'(bus.d_stall), 1);
      step();
      chk("hold_ctrl", 128'(bus.e_ctrl), 'h5A);
      chk("hold_valA", 128'(bus.e_valA), 'h1234);
      chk("hold_dst", 128'(bus.e_dstReg), 6);
    end

    // Reset mid-stream clears E
    idle(); reset = 1;
    step();
    chk("rst_mid_valid", 128'(bus.e_valid), 0);
    chk("rst_mid_valA", 128'(bus.e_valA), 0);
    chk("rst_mid_ctrl", 128'(bus.e_ctrl), 0);
`ifdef DECODE_STALL_CNT_EN
    chk("rst_mid_cnt", 128'(stall_cnt), 0);
`endif
    reset = 0;

    // Random traffic over a small register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bus.e_hold     = ($urandom_range(0, 7) == 0);
      bus.flush      = ($urandom_range(0, 9) == 0);
      bus.d_valid    = ($urandom_range(0, 3) != 0);
      bus.d_srcA     = RA_W'($urandom_range(0, 3));
      bus.d_srcB     = RA_W'($urandom_range(0, 3));
      bus.d_useA     = 1'($urandom);
      bus.d_useB     = 1'($urandom);
      bus.d_dstReg   = RA_W'($urandom_range(0, 3));
      bus.d_writeReg = ($urandom_range(0, 3) != 0);
      bus.d_isLoad   = ($urandom_range(0, 2) == 0);
      bus.d_ctrl     = 8'($urandom);
      bus.d_rvalA    = $urandom;
      bus.d_rvalB    = $urandom;
      bus.e_aluOut   = $urandom;
      bus.m_dstReg   = RA_W'($urandom_range(0, 3));
      bus.m_writeReg = 1'($urandom);
      bus.m_val      = $urandom;
      bus.w_dstReg   = RA_W'($urandom_range(0, 3));
      bus.w_writeReg = 1'($urandom);
      bus.w_val      = $urandom;
      step();
    end
    reset = 0;
    idle();
    step();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decode_forward.md
Name: decode_forward

Overview:
- Decode stage of the 5-stage pipeline, directly downstream of the register file.
- Consumes the regfile read data (d_rvalA/d_rvalB) and selects the freshest operand by priority: E forward, then M, then W, then regfile.
- Detects load-use hazards, then stalls fetch/decode and inserts a bubble.
- Owns the D/E pipeline register that feeds the execute stage.

Parameters:
- XLEN, 32, datapath width (matches regfile).
- RA_W, 5, register address width.
- CTRL_W, 8, opaque control bundle carried from D to E.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- d_valid  in  1  F/D register holds a real instruction.
- d_srcA, d_srcB  in  RA_W  source registers (also drive regfile srcA/srcB).
- d_useA, d_useB  in  1  instruction actually reads srcA/srcB.
- d_dstReg  in  RA_W  destination register.
- d_writeReg  in  1  instruction writes dstReg.
- d_isLoad  in  1  instruction is a load.
- d_ctrl  in  CTRL_W  control bundle.
- d_rvalA, d_rvalB  in  XLEN  regfile read data.
- e_aluOut  in  XLEN  execute result of the instruction currently in E.
- m_dstReg  in  RA_W  M-stage destination.
- m_writeReg  in  1  M-stage write enable.
- m_val  in  XLEN  M-stage result (load data when M is a load).
- w_dstReg  in  RA_W  W-stage destination (same as regfile dstReg).
- w_writeReg  in  1  W-stage write enable (same as regfile writeReg).
- w_val  in  XLEN  W-stage data (same as regfile data).
- e_hold  in  1  downstream stall; freeze the D/E register.
- flush  in  1  squash the instruction in D (branch redirect).
- d_stall  out  1  hold PC and F/D register this cycle (combinational).
- e_valid  out  1  D/E register valid.
- e_valA, e_valB  out  XLEN  forwarded operands.
- e_dstReg  out  RA_W  D/E register destination.
- e_writeReg  out  1  D/E register write enable.
- e_isLoad  out  1  D/E register load flag.
- e_ctrl  out  CTRL_W  D/E register control bundle.

Behaviour:
- Reset (synchronous, active-high): all e_* outputs are 0, so e_valid=0 and E holds a bubble. Reset has priority over every other input.
- Operand select, per source X in {A,B}:
  - If srcX==0, the value is 0; no forward and no hazard.
  - Else, if E is valid, e_writeReg=1, e_dstReg==srcX and e_isLoad=0, use e_aluOut.
  - Else, if m_writeReg=1 and m_dstReg==srcX, use m_val.
  - Else, if w_writeReg=1 and w_dstReg==srcX, use w_val. This covers the regfile write that is not yet visible this cycle.
  - Else use d_rvalX.
- Load-use hazard: d_valid, d_useX, srcX≠0, e_valid, e_isLoad, e_writeReg and e_dstReg==srcX, for either source.
- d_stall = e_hold | (hazard & ~flush).
- D/E register update, priority order:
  1. reset.
  2. e_hold: hold every e_* output.
  3. flush: load a bubble (e_valid=0, e_writeReg=0, e_isLoad=0; other fields don't-care, driven to 0).
  4. hazard: load a bubble. F/D holds via d_stall, and the instruction re-decodes next cycle, when the load is in M and m_val forwards.
  5. Otherwise load d_valid, the selected operands, d_dstReg, d_writeReg & d_valid, d_isLoad & d_valid, d_ctrl.
- Latency: one cycle from D to E outputs; one bubble per load-use hazard.
- Simultaneous events: flush together with hazard gives a bubble and d_stall=0. e_hold together with flush keeps E held; flush is the caller's responsibility to reassert.
- Register 0 is never a forward target, even if a stage reports dstReg=0 with writeReg=1.
- A bubble in E never forwards and never causes a hazard.

Optional Feature:
- Macro DECODE_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0], cleared by reset. It increments each cycle that hazard & ~flush & ~e_hold holds, and saturates at 16'hFFFF.
- Undefined: no port and no logic.

Decomposition:
- Shared package: XLEN, RA_W, CTRL_W defaults; REG_ZERO constant; D/E bundle typedef (valid, valA, valB, dstReg, writeReg, isLoad, ctrl).
- One natural sub-module, fwd_mux, instantiated twice (A and B). It performs the combinational priority select and outputs value plus load-hazard flag.

Test Plan:
- W-stage forward: w_writeReg=1, w_dstReg=3, w_val=0x55, d_srcA=3, d_rvalA=0x11 -> next cycle e_valA=0x55.
- E-over-M priority: E ALU with dst 5, e_aluOut=0xA; m_dstReg=5, m_val=0xB; d_srcB=5 -> e_valB=0xA.
- Load-use: E holds a load to r2, D reads r2 -> d_stall=1 for one cycle and e_valid=0. Next cycle, with m_val=0x77 -> e_valA=0x77, d_stall=0.
- r0 source: d_srcA=0, M writing r0 with 0xFF -> e_valA=0; no stall with a load to r0 in E.
- Flush with hazard: flush=1 during load-use -> d_stall=0, next e_valid=0. e_hold=1 for 3 cycles -> e_* unchanged.
- Reset mid-stream: reset=1 while e_valid=1 -> next edge all e_* are 0; stall_cnt=0 when DECODE_STALL_CNT_EN is defined.
